sr_latch_monitor: RTL and testbench

Clocked, synthesizable response checker for the SR latch family (NOR-style active-high inputs or NAND-style active-low inputs). It samples the stimulus applied to a latch under test together with the latch's Q/Qn outputs, maintains a reference model of the expected state, and flags and counts mismatches and forbidden-input events. It sits beside the latch under test in the latch benches, on the receiving end of the stimulus sequence, so pass/fail is computed in hardware instead of read from monitor text.

---
 rtl/sr_latch_monitor.sv | 178 +++++++++++++++++
 tb/tb_sr_latch_monitor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_monitor.sv
// Clocked response checker for an SR latch under test. Keeps a reference model of
// the expected latch state and flags and counts mismatches and forbidden-input events.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_UNKNOWN | latch state undefined (after reset or forbidden release)
//   ST_SETTLE  | expected state known, waiting for the latch to respond
//   ST_CHECK   | expected state known, Q/Qn compared every cycle
//   ST_FORB    | forbidden inputs applied, both outputs checked at NAND_MODE
module sr_latch_monitor #(
    parameter logic NAND_MODE = 1'b0,
    parameter int   SETTLE    = 2,
    parameter int   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qn,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] forb_cnt
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CHECK   = 2'd2,
        ST_FORB    = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    logic             s_q, r_q, q_q, qn_q;
    logic             s_d, r_d, q_d, qn_d;
    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             exp_q_q, exp_q_d;
    logic             exp_valid_q, exp_valid_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] forb_cnt_q, forb_cnt_d;

    logic set_a, rst_a, is_sr, is_forb, redirect;
    logic check_en, resp_ok;

    always_comb begin
        s_d      = s;
        r_d      = r;
        q_d      = q;
        qn_d     = qn;
        set_a    = s_q ^ NAND_MODE;
        rst_a    = r_q ^ NAND_MODE;
        is_sr    = set_a ^ rst_a;
        is_forb  = set_a & rst_a;
        // a SET/RESET that disagrees with the model restarts settling
        redirect = is_sr && (set_a != exp_q_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q          <= NAND_MODE;
            r_q          <= NAND_MODE;
            q_q          <= 1'b0;
            qn_q         <= 1'b0;
            state_q      <= ST_UNKNOWN;
            cnt_q        <= '0;
            exp_q_q      <= 1'b0;
            exp_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            forb_cnt_q   <= '0;
        end else begin
            s_q          <= s_d;
            r_q          <= r_d;
            q_q          <= q_d;
            qn_q         <= qn_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            exp_q_q      <= exp_q_d;
            exp_valid_q  <= exp_valid_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            forb_cnt_q   <= forb_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_q_d = exp_q_q;
        case (state_q)
            ST_UNKNOWN: begin
                if (is_forb) begin
                    state_d = ST_FORB;
                    cnt_d   = SETTLE_LD;
                end else if (is_sr) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                    exp_q_d = set_a;
                end
            end
            ST_SETTLE, ST_CHECK: begin
                if (is_forb) begin
                    state_d = ST_FORB;
                    cnt_d   = SETTLE_LD;
                end else if (redirect) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                    exp_q_d = set_a;
                end else if (state_q == ST_SETTLE) begin
                    if (cnt_q == 4'd0) state_d = ST_CHECK;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                if (is_sr) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                    exp_q_d = set_a;
                end else if (!is_forb) begin
                    state_d = ST_UNKNOWN;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
        exp_valid_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    end

    // The terminal settle cycle already judges the first response sample; a cycle
    // whose inputs are leaving the current expectation is never judged.
    always_comb begin
        check_en = 1'b0;
        resp_ok  = 1'b1;
        case (state_q)
            ST_SETTLE: begin
                check_en = (cnt_q == 4'd0) && !is_forb && !redirect;
                resp_ok  = (q_q == exp_q_q) && (qn_q == ~exp_q_q);
            end
            ST_CHECK: begin
                check_en = !is_forb && !redirect;
                resp_ok  = (q_q == exp_q_q) && (qn_q == ~exp_q_q);
            end
            ST_FORB: begin
                check_en = (cnt_q == 4'd0) && is_forb;
                resp_ok  = (q_q == NAND_MODE) && (qn_q == NAND_MODE);
            end
            default: begin
                check_en = 1'b0;
                resp_ok  = 1'b1;
            end
        endcase
        err_d        = check_en && !resp_ok;
        err_sticky_d = err_sticky_q | err_d;
        err_cnt_d    = err_cnt_q;
        if (err_d && (err_cnt_q != {CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
        forb_cnt_d = forb_cnt_q;
        if ((state_d == ST_FORB) && (state_q != ST_FORB) && (forb_cnt_q != {CNT_W{1'b1}}))
            forb_cnt_d = forb_cnt_q + 1'b1;
    end

    assign exp_q      = exp_q_q;
    assign exp_valid  = exp_valid_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign forb_cnt   = forb_cnt_q;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Bench for sr_latch_monitor: NOR, NAND and narrow-counter instances share one
// stimulus stream; expected outputs are queued with the cycle they become due.
module tb_sr_latch_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s = 1'b0, r = 1'b0, q = 1'b0, qn = 1'b1;

    logic       eq [3];
    logic       ev [3];
    logic       er [3];
    logic       es [3];
    logic [7:0] ecnt0, ecnt1, fcnt0, fcnt1;
    logic [1:0] ecnt2, fcnt2;

    typedef struct {
        int         due;
        int         inst;
        int         sel;
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t       sbq[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_mis = 0;
    logic [7:0] got;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sr_latch_monitor #(.NAND_MODE(1'b0), .SETTLE(2), .CNT_W(8)) u_nor (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .qn(qn),
        .exp_q(eq[0]), .exp_valid(ev[0]), .err(er[0]), .err_sticky(es[0]),
        .err_cnt(ecnt0), .forb_cnt(fcnt0));

    sr_latch_monitor #(.NAND_MODE(1'b1), .SETTLE(2), .CNT_W(8)) u_nand (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .qn(qn),
        .exp_q(eq[1]), .exp_valid(ev[1]), .err(er[1]), .err_sticky(es[1]),
        .err_cnt(ecnt1), .forb_cnt(fcnt1));

    sr_latch_monitor #(.NAND_MODE(1'b0), .SETTLE(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .qn(qn),
        .exp_q(eq[2]), .exp_valid(ev[2]), .err(er[2]), .err_sticky(es[2]),
        .err_cnt(ecnt2), .forb_cnt(fcnt2));

    // sel: 0 exp_q, 1 exp_valid, 2 err, 3 err_sticky, 4 err_cnt, 5 forb_cnt
    function automatic logic [7:0] obs(input int inst, input int sel);
        logic [7:0] ec, fc;
        case (inst)
            0:       begin ec = ecnt0;          fc = fcnt0;          end
            1:       begin ec = ecnt1;          fc = fcnt1;          end
            default: begin ec = {6'd0, ecnt2};  fc = {6'd0, fcnt2};  end
        endcase
        case (sel)
            0:       return {7'd0, eq[inst]};
            1:       return {7'd0, ev[inst]};
            2:       return {7'd0, er[inst]};
            3:       return {7'd0, es[inst]};
            4:       return ec;
            default: return fc;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s_i, input logic r_i, input logic q_i, input logic qn_i);
        s = s_i; r = r_i; q = q_i; qn = qn_i;
    endtask

    task automatic push(input int due, input int inst, input int sel, input logic [7:0] val, input string nm);
        exp_t e;
        e.due = due; e.inst = inst; e.sel = sel; e.val = val; e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) rst = 1'b0;
            if (k == 0)
                for (int sel = 0; sel < 6; sel++) begin
                    push(cyc + 1, 0, sel, 8'd0, "reset_nor");
                    push(cyc + 1, 1, sel, 8'd0, "reset_nand");
                    push(cyc + 1, 2, sel, 8'd0, "reset_sat");
                end
            push(cyc + 1, 0, 2, 8'd0, "reset_hold_err");
            push(cyc + 1, 0, 1, 8'd0, "reset_hold_valid");
            tick();
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i].due == cyc) begin
                    got = obs(sbq[i].inst, sbq[i].sel);
                    n_vec++;
                    if (got !== sbq[i].val) begin
                        n_mis++;
                        $display("FAIL %s inst%0d cyc %0d: got %0d want %0d", sbq[i].nm, sbq[i].inst, cyc, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end
        end
    endtask

    task automatic test_ideal_nor();
        bit ps [4] = '{1, 0, 0, 0};
        bit pr [4] = '{0, 0, 1, 0};
        bit pq [4] = '{1, 1, 0, 0};
        int plen [4] = '{10, 4, 6, 4};
        pulse_rst();
        for (int p = 0; p < 4; p++) begin
            drive(ps[p], pr[p], pq[p], ~pq[p]);
            push(cyc + 2, 0, 0, {7'd0, pq[p]}, "ideal_exp_q");
            push(cyc + 2, 0, 1, 8'd1, "ideal_exp_valid");
            for (int n = 0; n < plen[p]; n++) begin
                push(cyc + 1, 0, 2, 8'd0, "ideal_err");
                push(cyc + 1, 0, 4, 8'd0, "ideal_err_cnt");
                tick();
                for (int i = sbq.size() - 1; i >= 0; i--)
                    if (sbq[i].due == cyc) begin
                        got = obs(sbq[i].inst, sbq[i].sel);
                        n_vec++;
                        if (got !== sbq[i].val) begin
                            n_mis++;
                            $display("FAIL %s inst%0d cyc %0d: got %0d want %0d", sbq[i].nm, sbq[i].inst, cyc, got, sbq[i].val);
                        end
                        sbq.delete(i);
                    end
            end
        end
    endtask

    // Q stuck at 0 while set is held; the CNT_W=2 instance sees the same mismatch.
    task automatic test_stuck_and_saturate();
        int c;
        pulse_rst();
        c = cyc;
        drive(1, 0, 0, 1);
        for (int k = 1; k <= 13; k++) begin
            push(c + k, 0, 2, (k >= 4) ? 8'd1 : 8'd0, "stuck_err");
            push(c + k, 0, 3, (k >= 4) ? 8'd1 : 8'd0, "stuck_sticky");
            push(c + k, 0, 4, (k >= 4) ? 8'(k - 3) : 8'd0, "stuck_err_cnt");
            push(c + k, 2, 4, (k >= 6) ? 8'd3 : ((k >= 4) ? 8'(k - 3) : 8'd0), "sat_err_cnt");
            tick();
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i].due == cyc) begin
                    got = obs(sbq[i].inst, sbq[i].sel);
                    n_vec++;
                    if (got !== sbq[i].val) begin
                        n_mis++;
                        $display("FAIL %s inst%0d cyc %0d: got %0d want %0d", sbq[i].nm, sbq[i].inst, cyc, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end
        end
    endtask

    // Follows test_stuck_and_saturate: reset lands while err is active.
    task automatic test_rst_mid();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                rst = 1'b0;
                drive(0, 0, 0, 1);
            end
            if (k == 0) begin
                for (int sel = 0; sel < 6; sel++) push(cyc + 1, 0, sel, 8'd0, "rst_mid_nor");
                push(cyc + 1, 2, 4, 8'd0, "rst_mid_sat_cnt");
            end else begin
                push(cyc + 1, 0, 2, 8'd0, "rst_hold_err");
                push(cyc + 1, 0, 1, 8'd0, "rst_hold_valid");
                push(cyc + 1, 0, 3, 8'd0, "rst_hold_sticky");
            end
            tick();
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i].due == cyc) begin
                    got = obs(sbq[i].inst, sbq[i].sel);
                    n_vec++;
                    if (got !== sbq[i].val) begin
                        n_mis++;
                        $display("FAIL %s inst%0d cyc %0d: got %0d want %0d", sbq[i].nm, sbq[i].inst, cyc, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end
        end
    endtask

    task automatic test_forbid_nor();
        int c;
        pulse_rst();
        c = cyc;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) drive(1, 1, 0, 0);
            if (k == 6) drive(0, 0, 0, 0);
            if (k == 9) drive(1, 0, 1, 0);
            push(c + k, 0, 2, 8'd0, "forb_err");
            if (k == 2) begin
                push(c + k, 0, 5, 8'd1, "forb_cnt_entry");
                push(c + k, 0, 1, 8'd0, "forb_valid");
            end
            if (k == 7) push(c + k, 0, 1, 8'd0, "forb_release_valid");
            if (k == 10) begin
                push(c + k, 0, 1, 8'd1, "forb_reset_valid");
                push(c + k, 0, 0, 8'd1, "forb_reset_exp_q");
            end
            if (k == 12) begin
                push(c + k, 0, 5, 8'd1, "forb_cnt_final");
                push(c + k, 0, 4, 8'd0, "forb_err_cnt");
            end
            tick();
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i].due == cyc) begin
                    got = obs(sbq[i].inst, sbq[i].sel);
                    n_vec++;
                    if (got !== sbq[i].val) begin
                        n_mis++;
                        $display("FAIL %s inst%0d cyc %0d: got %0d want %0d", sbq[i].nm, sbq[i].inst, cyc, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end
        end
    endtask

    task automatic test_nand();
        int c;
        drive(1, 1, 1, 0);
        pulse_rst();
        c = cyc;
        for (int k = 1; k <= 14; k++) begin
            if (k == 1)  drive(0, 1, 1, 0);
            if (k == 6)  drive(0, 0, 1, 1);
            if (k == 11) drive(0, 0, 1, 0);
            push(c + k, 1, 2, (k >= 12) ? 8'd1 : 8'd0, "nand_err");
            if (k == 2) begin
                push(c + k, 1, 0, 8'd1, "nand_exp_q");
                push(c + k, 1, 1, 8'd1, "nand_exp_valid");
            end
            if (k == 7) begin
                push(c + k, 1, 5, 8'd1, "nand_forb_cnt");
                push(c + k, 1, 1, 8'd0, "nand_forb_valid");
            end
            if (k == 14) begin
                push(c + k, 1, 4, 8'd3, "nand_err_cnt");
                push(c + k, 1, 3, 8'd1, "nand_sticky");
                push(c + k, 1, 5, 8'd1, "nand_forb_cnt_final");
            end
            tick();
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i].due == cyc) begin
                    got = obs(sbq[i].inst, sbq[i].sel);
                    n_vec++;
                    if (got !== sbq[i].val) begin
                        n_mis++;
                        $display("FAIL %s inst%0d cyc %0d: got %0d want %0d", sbq[i].nm, sbq[i].inst, cyc, got, sbq[i].val);
                    end
                    sbq.delete(i);
                end
        end
    endtask

    initial begin
        test_reset();
        test_ideal_nor();
        test_stuck_and_saturate();
        test_rst_mid();
        test_forbid_nor();
        test_nand();
        if (sbq.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL scoreboard_leftover: got %0d pending entries, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
